// File: rtl/ros_freq_pkg.sv
// Shared types and helpers for the ring-oscillator frequency counter.
package ros_freq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_t;

  localparam int SYNC_STAGES = 2;

  // Window length in clk cycles: 2^(gate_log2 + 2*gate_sel).
  function automatic logic [31:0] gate_len(input int unsigned gate_log2,
                                           input logic [1:0]  gate_sel);
    return 32'd1 << (gate_log2 + {29'd0, gate_sel, 1'b0});
  endfunction

endpackage

// File: rtl/ros_sync2.sv
// Two-flop synchronizer bringing the free-running RO output into the clk domain.
module ros_sync2
  import ros_freq_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= '0;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ros_freq_counter.sv
// Counts RO rising edges over a 2^(GATE_LOG2+2*gate_sel) clk window and latches the count.
// Define ROS_FREQ_SAT_EN to saturate the edge counter and report sticky overflow on ovf.
module ros_freq_counter
  import ros_freq_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int GATE_LOG2 = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             ro_in,
  input  logic             start,
  input  logic             cont,
  input  logic [1:0]       gate_sel,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] result,
  input  logic [1:0]       byte_sel,
  output logic [7:0]       byte_out,
  output logic             ovf
);

  localparam int GW = GATE_LOG2 + 6;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_ro_s;
  logic             r_ro_prev;
  logic             r_rise;
  logic [GW-1:0]    r_gate_cnt;
  logic [GW-1:0]    w_gate_load;
  logic [CNT_W-1:0] r_edge_cnt;
  logic [CNT_W-1:0] w_edge_nxt;
  logic [CNT_W-1:0] r_result;
  logic             r_valid;
  logic             r_ovf;
  logic             w_hit;
  logic             w_term;
  logic             w_accept;
  logic [31:0]      w_len;
  logic [31:0]      w_res32;

  ros_sync2 u_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_d     (ro_in),
    .o_q     (w_ro_s)
  );

  // Edge detector runs in every state; RO periods of 2 clk or less alias.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ro_prev <= 1'b0;
      r_rise    <= 1'b0;
    end else begin
      r_ro_prev <= w_ro_s;
      r_rise    <= w_ro_s & ~r_ro_prev;
    end
  end

  assign w_len       = gate_len(GATE_LOG2, gate_sel);
  assign w_gate_load = GW'(w_len - 32'd1);
  assign w_term      = (r_state == GATE) && (r_gate_cnt == '0);
  assign w_accept    = (r_state == IDLE) && ena && start;

`ifdef ROS_FREQ_SAT_EN
  assign w_hit      = r_rise & (&r_edge_cnt);
  assign w_edge_nxt = w_hit ? r_edge_cnt : r_edge_cnt + CNT_W'(r_rise);
`else
  assign w_hit      = 1'b0;
  assign w_edge_nxt = r_edge_cnt + CNT_W'(r_rise);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (ena && start) w_state_nxt = GATE;
      GATE:    if (!ena || (w_term && !cont)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == GATE);
  end

  // The terminal cycle's own rise goes into the result so back-to-back windows lose nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_result   <= '0;
      r_valid    <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_accept) begin
        r_gate_cnt <= w_gate_load;
        r_edge_cnt <= '0;
        r_ovf      <= 1'b0;
      end else if (r_state == GATE && ena) begin
        if (w_hit) r_ovf <= 1'b1;
        if (w_term) begin
          r_result <= w_edge_nxt;
          r_valid  <= 1'b1;
          if (cont) begin
            r_gate_cnt <= w_gate_load;
            r_edge_cnt <= '0;
          end
        end else begin
          r_gate_cnt <= r_gate_cnt - GW'(1);
          r_edge_cnt <= w_edge_nxt;
        end
      end
    end
  end

  assign valid    = r_valid;
  assign result   = r_result;
  assign ovf      = r_ovf;
  assign w_res32  = 32'(r_result);
  assign byte_out = w_res32[{byte_sel, 3'b000} +: 8];

endmodule

// File: tb/tb_ros_freq_counter.sv
// Directed bench for ros_freq_counter: a 16-bit and an 8-bit instance share all inputs.
module tb_ros_freq_counter;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        ena      = 1'b0;
  logic        ro_in    = 1'b0;
  logic        start    = 1'b0;
  logic        cont     = 1'b0;
  logic [1:0]  gate_sel = 2'd0;
  logic [1:0]  byte_sel = 2'd0;

  logic        busy, valid, ovf;
  logic [15:0] result;
  logic [7:0]  byte_out;
  logic        busy8, valid8, ovf8;
  logic [7:0]  result8;
  logic [7:0]  byte_out8;

  int n_pass  = 0;
  int n_total = 0;
  int ro_half = 0;
  int cyc     = 0;
  int n_busy, n_valid, sum_res;
  int vpos[8];
  int vres[8];

  ros_freq_counter #(.CNT_W(16), .GATE_LOG2(10)) u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ro_in(ro_in), .start(start), .cont(cont),
    .gate_sel(gate_sel), .busy(busy), .valid(valid), .result(result),
    .byte_sel(byte_sel), .byte_out(byte_out), .ovf(ovf)
  );

  ros_freq_counter #(.CNT_W(8), .GATE_LOG2(10)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ro_in(ro_in), .start(start), .cont(cont),
    .gate_sel(gate_sel), .busy(busy8), .valid(valid8), .result(result8),
    .byte_sel(byte_sel), .byte_out(byte_out8), .ovf(ovf8)
  );

  always #5 clk = ~clk;

  // RO toggles at 3 ns mod 5 so its edges never coincide with clk edges.
  initial begin
    #3;
    forever begin
      if (ro_half == 0) begin
        ro_in = 1'b0;
        #10;
      end else begin
        #(ro_half) ro_in = ~ro_in;
      end
    end
  end

  task automatic clear_stats();
    n_busy  = 0;
    n_valid = 0;
    sum_res = 0;
    for (int i = 0; i < 8; i++) begin
      vpos[i] = 0;
      vres[i] = 0;
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy) n_busy++;
      if (valid) begin
        if (n_valid < 8) begin
          vpos[n_valid] = cyc;
          vres[n_valid] = int'(result);
        end
        sum_res += int'(result);
        n_valid++;
      end
    end
  endtask

  task automatic set_ro(input int period_clk);
    ro_half = period_clk * 5;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    run_cycles(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", valid); else n_pass++;
    n_total++; if (result !== 16'd0) $display("FAIL rst_result: got %0d want 0", result); else n_pass++;
    n_total++; if (ovf !== 1'b0) $display("FAIL rst_ovf: got %b want 0", ovf); else n_pass++;
    n_total++; if (byte_out !== 8'd0) $display("FAIL rst_byte: got %h want 00", byte_out); else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ena   = 1'b1;
  endtask

  task automatic test_single();
    set_ro(8);
    gate_sel = 2'd0;
    cont     = 1'b0;
    clear_stats();
    pulse_start();
    run_cycles(299);
    pulse_start();
    run_cycles(800);
    n_total++; if (n_busy !== 1024) $display("FAIL t1_busy_cycles: got %0d want 1024", n_busy); else n_pass++;
    n_total++; if (n_valid !== 1) $display("FAIL t1_valid_count: got %0d want 1", n_valid); else n_pass++;
    n_total++; if (result !== 16'd128) $display("FAIL t1_result: got %0d want 128", result); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL t1_busy_end: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_byte_sel(input logic [15:0] er, input logic [7:0] e8);
    logic [7:0] eb;
    logic [7:0] eb8;
    for (int s = 0; s < 4; s++) begin
      byte_sel = 2'(s);
      #1;
      case (s)
        0:       eb = er[7:0];
        1:       eb = er[15:8];
        default: eb = 8'h00;
      endcase
      eb8 = (s == 0) ? e8 : 8'h00;
      n_total++; if (byte_out !== eb) $display("FAIL byte_sel%0d: got %h want %h", s, byte_out, eb); else n_pass++;
      n_total++; if (byte_out8 !== eb8) $display("FAIL byte8_sel%0d: got %h want %h", s, byte_out8, eb8); else n_pass++;
    end
    byte_sel = 2'd0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_gate_sel();
    set_ro(8);
    gate_sel = 2'd1;
    cont     = 1'b0;
    clear_stats();
    pulse_start();
    run_cycles(99);
    gate_sel = 2'd0;
    run_cycles(4100);
    n_total++; if (n_busy !== 4096) $display("FAIL t2_busy_cycles: got %0d want 4096", n_busy); else n_pass++;
    n_total++; if (n_valid !== 1) $display("FAIL t2_valid_count: got %0d want 1", n_valid); else n_pass++;
    n_total++; if (result !== 16'd512) $display("FAIL t2_result: got %0d want 512", result); else n_pass++;
  endtask

  task automatic test_back_to_back();
    set_ro(10);
    gate_sel = 2'd0;
    cont     = 1'b1;
    clear_stats();
    pulse_start();
    run_cycles(2147);
    cont = 1'b0;
    run_cycles(1100);
    n_total++; if (n_valid !== 3) $display("FAIL t3_valid_count: got %0d want 3", n_valid); else n_pass++;
    n_total++; if (n_busy !== 3072) $display("FAIL t3_busy_cycles: got %0d want 3072", n_busy); else n_pass++;
    n_total++; if (vpos[1] - vpos[0] !== 1024) $display("FAIL t3_gap01: got %0d want 1024", vpos[1] - vpos[0]); else n_pass++;
    n_total++; if (vpos[2] - vpos[1] !== 1024) $display("FAIL t3_gap12: got %0d want 1024", vpos[2] - vpos[1]); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (vres[i] < 101 || vres[i] > 103) $display("FAIL t3_result%0d: got %0d want 101..103", i, vres[i]);
      else n_pass++;
    end
    n_total++; if (sum_res < 307 || sum_res > 308) $display("FAIL t3_sum: got %0d want 307..308", sum_res); else n_pass++;
  endtask

  task automatic test_overflow();
    set_ro(4);
    gate_sel = 2'd1;
    cont     = 1'b0;
    clear_stats();
    pulse_start();
    run_cycles(4200);
    n_total++; if (result !== 16'd1024) $display("FAIL t4_result16: got %0d want 1024", result); else n_pass++;
    n_total++; if (ovf !== 1'b0) $display("FAIL t4_ovf16: got %b want 0", ovf); else n_pass++;
`ifdef ROS_FREQ_SAT_EN
    n_total++; if (result8 !== 8'hFF) $display("FAIL t4_result8: got %h want ff", result8); else n_pass++;
    n_total++; if (ovf8 !== 1'b1) $display("FAIL t4_ovf8: got %b want 1", ovf8); else n_pass++;
`else
    n_total++; if (result8 !== 8'h00) $display("FAIL t4_result8: got %h want 00", result8); else n_pass++;
    n_total++; if (ovf8 !== 1'b0) $display("FAIL t4_ovf8: got %b want 0", ovf8); else n_pass++;
`endif
  endtask

  task automatic test_abort();
    set_ro(8);
    gate_sel = 2'd0;
    cont     = 1'b0;
    clear_stats();
    pulse_start();
    run_cycles(499);
    ena = 1'b0;
    run_cycles(1);
    n_total++; if (busy !== 1'b0) $display("FAIL t5_busy_after_ena: got %b want 0", busy); else n_pass++;
    ena = 1'b1;
    clear_stats();
    run_cycles(1100);
    n_total++; if (n_valid !== 0) $display("FAIL t5_no_valid: got %0d want 0", n_valid); else n_pass++;
    n_total++; if (n_busy !== 0) $display("FAIL t5_idle: got %0d want 0", n_busy); else n_pass++;
    n_total++; if (result !== 16'd1024) $display("FAIL t5_result_hold: got %0d want 1024", result); else n_pass++;
    n_total++; if (ovf8 !== 1'b0) $display("FAIL t5_ovf_cleared: got %b want 0", ovf8); else n_pass++;

    pulse_start();
    run_cycles(200);
    n_total++; if (busy !== 1'b1) $display("FAIL t5_busy_pre_rst: got %b want 1", busy); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL t5_rst_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (result !== 16'd0) $display("FAIL t5_rst_result: got %0d want 0", result); else n_pass++;
    n_total++; if (result8 !== 8'd0) $display("FAIL t5_rst_result8: got %0d want 0", result8); else n_pass++;
    n_total++; if (valid !== 1'b0) $display("FAIL t5_rst_valid: got %b want 0", valid); else n_pass++;
    n_total++; if (byte_out !== 8'd0) $display("FAIL t5_rst_byte: got %h want 00", byte_out); else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_byte_sel(16'h0080, 8'h80);
    test_gate_sel();
    test_byte_sel(16'h0200, 8'h00);
    test_back_to_back();
    test_overflow();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
